// File: rtl/rf_op_pkg.sv
// rf_op_pkg: shared definitions for the register-file operation sequencer.
//   - DATA_W_DEF / ADDR_W_DEF: default datapath and register-index widths
//   - INSTR_W and instruction field bit positions ([8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2)
//   - opcode constants OP_ADD..OP_NOP
//   - sequencer state encoding
//   - field extraction helpers
package rf_op_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned INSTR_W    = 9;

    localparam int unsigned OP_MSB  = 8;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_MSB = 3;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_MSB = 1;
    localparam int unsigned RS2_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StMul,
        StWb
    } seq_state_e;

    function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset, abandons any multiply in progress
//   start_i     one-cycle pulse, samples a_i/b_i
//   a_i, b_i    DATA_W-bit unsigned operands
//   done_o      high in the cycle of the final iteration (DATA_W cycles after start)
//   product_o   2*DATA_W-bit product, valid while done_o is high
module seq_shift_add_mul #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam logic [4:0] LastIter = 5'(DATA_W - 1);

    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   mplier_q;
    logic [4:0]          cnt_q;
    logic                run_q;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // The last partial product is folded in combinationally so the result is
    // available in the same cycle as done_o.
    assign done_o    = run_q && (cnt_q == LastIter);
    assign product_o = acc_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: execute/write-back sequencer in front of a 4x16-bit register file.
// Accepts one instruction at a time, reads both operands from the RF, computes the
// result and issues a single write-back pulse. Maintains Zero/Carry flags.
// Optional feature: define RF_OP_SEQ_MUL_EN to build the 16-cycle iterative multiplier;
// without it op 101 behaves as NOP.
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   Instr_Valid/Instr_Ready      instruction handshake, Instr = {op, rd, rs1, rs2}
//   Read_Address1/2, Read_Data1/2  RF combinational read ports
//   Write_Enable/Address/Data    RF write port
//   Done                         one-cycle pulse at write-back
//   Busy                         high whenever not idle
//   Zero, Carry                  registered result flags
module rf_op_sequencer import rf_op_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Instr_Valid,
    output logic                Instr_Ready,
    input  logic [INSTR_W-1:0]  Instr,
    output logic [ADDR_W-1:0]   Read_Address1,
    output logic [ADDR_W-1:0]   Read_Address2,
    input  logic [DATA_W-1:0]   Read_Data1,
    input  logic [DATA_W-1:0]   Read_Data2,
    output logic                Write_Enable,
    output logic [ADDR_W-1:0]   Write_Address,
    output logic [DATA_W-1:0]   Write_Data,
    output logic                Done,
    output logic                Busy,
    output logic                Zero,
    output logic                Carry
);

    seq_state_e          state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2:0]          op;
    logic                writes_back;

    assign op = instr_op(instr_q);

`ifdef RF_OP_SEQ_MUL_EN
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    // Operands are taken straight from the RF in READ, same values latched into op_a/op_b.
    seq_shift_add_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .start_i   (mul_start),
        .a_i       (Read_Data1),
        .b_i       (Read_Data2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign writes_back = (op != OP_NOP);
`else
    assign writes_back = (op != OP_NOP) && (op != OP_MUL);
`endif

    always_comb begin
        sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
        diff = {1'b0, op_a_q} - {1'b0, op_b_q};
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        ready_d  = ready_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef RF_OP_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (Instr_Valid && ready_q) begin
                    instr_d = Instr;
                    ready_d = 1'b0;
                    state_d = StRead;
                end
            end
            StRead: begin
                op_a_d  = Read_Data1;
                op_b_d  = Read_Data2;
                state_d = StExec;
`ifdef RF_OP_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = StMul;
                end
`endif
            end
            StExec: begin
                state_d = StWb;
                // NOP, and MUL when it is not built, leave result and flags untouched.
                case (op)
                    OP_ADD: begin
                        result_d = sum[DATA_W-1:0];
                        carry_d  = sum[DATA_W];
                        zero_d   = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        // Top bit of the widened difference is the borrow.
                        result_d = diff[DATA_W-1:0];
                        carry_d  = diff[DATA_W];
                        zero_d   = (diff[DATA_W-1:0] == '0);
                    end
                    OP_AND: begin
                        result_d = op_a_q & op_b_q;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a_q & op_b_q) == '0);
                    end
                    OP_OR: begin
                        result_d = op_a_q | op_b_q;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a_q | op_b_q) == '0);
                    end
                    OP_XOR: begin
                        result_d = op_a_q ^ op_b_q;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a_q ^ op_b_q) == '0);
                    end
                    OP_MOV: begin
                        result_d = op_a_q;
                        carry_d  = 1'b0;
                        zero_d   = (op_a_q == '0);
                    end
                    default: ;
                endcase
            end
`ifdef RF_OP_SEQ_MUL_EN
            StMul: begin
                if (mul_done) begin
                    result_d = mul_product[DATA_W-1:0];
                    carry_d  = |mul_product[2*DATA_W-1:DATA_W];
                    zero_d   = (mul_product[DATA_W-1:0] == '0);
                    state_d  = StWb;
                end
            end
`endif
            StWb: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            ready_q  <= 1'b1;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            ready_q  <= ready_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign Instr_Ready   = ready_q;
    assign Busy          = (state_q != StIdle);
    assign Done          = (state_q == StWb);
    assign Write_Enable  = Done && writes_back;
    assign Write_Address = instr_rd(instr_q);
    assign Write_Data    = result_q;
    assign Read_Address1 = instr_rs1(instr_q);
    assign Read_Address2 = instr_rs2(instr_q);
    assign Zero          = zero_q;
    assign Carry         = carry_q;

endmodule
